// File: rtl/pc_pkg.sv
//------------------------------------------------------------------------------
// pc_pkg : shared op encoding and default widths for the PC sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

    localparam int unsigned C_PC_W      = 12;
    localparam int unsigned C_OFF_W     = 8;
    localparam int unsigned C_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        NEXT   = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } pc_op_t;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
//------------------------------------------------------------------------------
// pc_ras : LIFO return-address stack with count, full and empty status
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_ras #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 12,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     push_data_i,
    output logic [W-1:0]     top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             full;
    logic             empty;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_idx  = IDX_W'(count_q);
    assign top_idx = IDX_W'(count_q - 1'b1);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (push_i && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is never reset: entries at or above count are unreachable.
    always_ff @(posedge clock) begin
        if (push_i && !full && !clear_i) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o   = mem_q[top_idx];
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// pc_sequencer : program counter with relative branch, jump, call and return
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned PC_W      = C_PC_W,
    parameter int unsigned OFF_W     = C_OFF_W,
    parameter int unsigned RAS_DEPTH = C_RAS_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PC_W-1:0]                  start_addr,
    input  logic                             advance,
    input  logic [2:0]                       op,
    input  logic                             taken,
    input  logic [OFF_W-1:0]                 offset,
    input  logic [PC_W-1:0]                  target,
    output logic [PC_W-1:0]                  pc_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            unf_q;
    logic            unf_d;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_clear;
    logic            ras_full;
    logic            ras_empty;

    assign pc_inc  = pc_q + 1'b1;
    assign off_ext = PC_W'($signed(offset));

    always_comb begin
        pc_d      = pc_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        if (start) begin
            pc_d      = start_addr;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            ras_clear = 1'b1;
        end else if (advance) begin
            case (pc_op_t'(op))
                BRANCH: pc_d = taken ? (pc_inc + off_ext) : pc_inc;
                JUMP:   pc_d = target;
                CALL: begin
                    pc_d = target;
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                    end
                end
                RET: begin
                    if (ras_empty) begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W),
        .CNT_W (CNT_W)
    ) u_ras (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (ras_clear),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    assign pc_out        = pc_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// tb_pc_sequencer : directed and random stimulus against a queue-based model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

    localparam int PC_W      = 12;
    localparam int OFF_W     = 8;
    localparam int RAS_DEPTH = 4;
    localparam int PC_MASK   = (1 << PC_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [PC_W-1:0]   start_addr = '0;
    logic              advance = 1'b0;
    logic [2:0]        op = 3'd0;
    logic              taken = 1'b0;
    logic [OFF_W-1:0]  offset = '0;
    logic [PC_W-1:0]   target = '0;
    logic [PC_W-1:0]   pc_out;
    logic [2:0]        ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_pc = 0;
    int m_stack[$];
    int m_ovf = 0;
    int m_unf = 0;

    pc_sequencer #(
        .PC_W      (PC_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .advance       (advance),
        .op            (op),
        .taken         (taken),
        .offset        (offset),
        .target        (target),
        .pc_out        (pc_out),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input int s, input int sa, input int adv, input int o,
                              input int tk, input int off, input int tgt);
        int d;
        if (s != 0) begin
            m_pc = sa;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (adv != 0) begin
            d = (off >= (1 << (OFF_W - 1))) ? off - (1 << OFF_W) : off;
            case (o)
                1: m_pc = (m_pc + 1 + (tk != 0 ? d : 0)) & PC_MASK;
                2: m_pc = tgt;
                3: begin
                    if (m_stack.size() < RAS_DEPTH) m_stack.push_back((m_pc + 1) & PC_MASK);
                    else m_ovf = 1;
                    m_pc = tgt;
                end
                4: begin
                    if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin
                        m_pc  = (m_pc + 1) & PC_MASK;
                        m_unf = 1;
                    end
                end
                default: m_pc = (m_pc + 1) & PC_MASK;
            endcase
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".pc"},  32'(pc_out),        32'(m_pc));
        check_eq({tag, ".cnt"}, 32'(ras_count),     32'(m_stack.size()));
        check_eq({tag, ".ovf"}, 32'(ras_overflow),  32'(m_ovf));
        check_eq({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input string tag, input int s, input int sa, input int adv,
                        input int o, input int tk, input int off, input int tgt);
        start      = (s != 0);
        start_addr = PC_W'(sa);
        advance    = (adv != 0);
        op         = 3'(o);
        taken      = (tk != 0);
        offset     = OFF_W'(off);
        target     = PC_W'(tgt);
        model_step(s, sa, adv, o, tk, off, tgt);
        @(posedge clock);
        #1;
        check_model(tag);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        advance = 1'b0;
        op      = 3'd0;
    endtask

    initial begin
        // reset state
        #1;
        check_eq("rst.pc",  32'(pc_out), 32'h0);
        check_eq("rst.cnt", 32'(ras_count), 32'h0);
        check_eq("rst.ovf", 32'(ras_overflow), 32'h0);
        check_eq("rst.unf", 32'(ras_underflow), 32'h0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // start then stall
        step("start100", 1, 'h100, 1, 2, 0, 0, 'h555);
        check_eq("start100.lit", 32'(pc_out), 32'h100);
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 0, 0, 0);
        check_eq("stall.lit", 32'(pc_out), 32'h100);

        // branches and wrap
        step("start010", 1, 'h010, 0, 0, 0, 0, 0);
        step("br_taken", 0, 0, 1, 1, 1, 'hFC, 0);
        check_eq("br_taken.lit", 32'(pc_out), 32'h00D);
        step("start010b", 1, 'h010, 0, 0, 0, 0, 0);
        step("br_not", 0, 0, 1, 1, 0, 'hFC, 0);
        check_eq("br_not.lit", 32'(pc_out), 32'h011);
        step("startFFF", 1, 'hFFF, 0, 0, 0, 0, 0);
        step("wrap", 0, 0, 1, 0, 0, 0, 0);
        check_eq("wrap.lit", 32'(pc_out), 32'h000);

        // nested call/return
        step("start020", 1, 'h020, 0, 0, 0, 0, 0);
        step("call200", 0, 0, 1, 3, 0, 0, 'h200);
        step("call300", 0, 0, 1, 3, 0, 0, 'h300);
        step("ret1", 0, 0, 1, 4, 0, 0, 0);
        check_eq("ret1.lit", 32'(pc_out), 32'h201);
        step("ret2", 0, 0, 1, 4, 0, 0, 0);
        check_eq("ret2.lit", 32'(pc_out), 32'h021);

        // overflow then drain
        step("start400", 1, 'h400, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("call_ovf", 0, 0, 1, 3, 0, 0, 'h500 + i * 'h10);
        check_eq("ovf.lit", 32'(ras_overflow), 32'h1);
        for (int i = 0; i < 4; i++) step("ret_drain", 0, 0, 1, 4, 0, 0, 0);
        check_eq("drain.lit", 32'(pc_out), 32'h401);

        // underflow cleared by start
        step("start050", 1, 'h050, 0, 0, 0, 0, 0);
        step("ret_unf", 0, 0, 1, 4, 0, 0, 0);
        check_eq("unf.lit", 32'(pc_out), 32'h051);
        step("unf_clr", 1, 'h060, 0, 0, 0, 0, 0);

        // asynchronous reset between edges with two entries on the stack
        step("call_a", 0, 0, 1, 3, 0, 0, 'h700);
        step("call_b", 0, 0, 1, 3, 0, 0, 'h710);
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("arst.pc",  32'(pc_out), 32'h0);
        check_eq("arst.cnt", 32'(ras_count), 32'h0);
        #1;
        reset = 1'b0;
        @(negedge clock);
        step("post_rst", 0, 0, 1, 0, 0, 0, 0);
        check_eq("post_rst.lit", 32'(pc_out), 32'h001);
        step("post_rst_ret", 0, 0, 1, 4, 0, 0, 0);

        // random
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 24) == 0) ? 1 : 0,
                 int'($urandom_range(0, PC_MASK)),
                 ($urandom_range(0, 4) != 0) ? 1 : 0,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)),
                 int'($urandom_range(0, PC_MASK)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 12: program-counter width in bits.
REQ-002 Parameter OFF_W, default 8: relative-branch offset width in bits, two's complement, OFF_W <= PC_W.
REQ-003 Parameter RAS_DEPTH, default 4: return-address stack entries, >= 1.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  load start_addr into PC, clear stack and error flags.
REQ-007 start_addr  in  PC_W  program entry address.
REQ-008 advance  in  1  current instruction retires this cycle; 0 = hold PC (stall).
REQ-009 op  in  3  pc_op_t: NEXT, BRANCH, JUMP, CALL, RET; other codes act as NEXT.
REQ-010 taken  in  1  condition result; qualifies BRANCH only.
REQ-011 offset  in  OFF_W  signed relative displacement.
REQ-012 target  in  PC_W  absolute destination for JUMP and CALL.
REQ-013 pc_out  out  PC_W  registered current PC.
REQ-014 ras_count  out  $clog2(RAS_DEPTH+1)  number of valid stack entries.
REQ-015 ras_overflow  out  1  sticky: CALL issued with stack full.
REQ-016 ras_underflow  out  1  sticky: RET issued with stack empty.

Function
REQ-017 All outputs are registered; a change of inputs affects outputs only after the next rising clock edge (1-cycle latency).
REQ-018 Priority: reset > start > advance; when start=1, op/advance are ignored that cycle.
REQ-019 advance=0 and start=0: PC, stack, count and flags hold.
REQ-020 NEXT: PC <= PC + 1.
REQ-021 BRANCH, taken=1: PC <= PC + 1 + sign_extend(offset); taken=0: PC <= PC + 1.
REQ-022 JUMP: PC <= target.
REQ-023 CALL, stack not full: push PC + 1, PC <= target, count +1.
REQ-024 CALL, stack full: no push, contents unchanged, PC <= target, ras_overflow <= 1.
REQ-025 RET, stack not empty: PC <= top entry, pop, count -1.
REQ-026 RET, stack empty: PC <= PC + 1, ras_underflow <= 1.
REQ-027 All PC arithmetic is modulo 2^PC_W; wrap past all-ones and below zero is silent and legal.
REQ-028 Stack is LIFO; only the top entry is observable through RET.
REQ-029 start: PC <= start_addr, count <= 0, both flags <= 0; stale entries never returned.
REQ-030 Flags remain set until reset or start.

Reset
REQ-031 reset=1 asynchronously forces pc_out=0, ras_count=0, ras_overflow=0, ras_underflow=0.
REQ-032 Stack storage need not be reset; it is unreachable while count=0.
REQ-033 Deassertion mid-program resumes from PC 0 on the first edge after release, with start and advance evaluated normally.

Structure
REQ-034 Shared package pc_pkg holds pc_op_t enum (NEXT=0, BRANCH=1, JUMP=2, CALL=3, RET=4) and default width constants.
REQ-035 Stack is one sub-module pc_ras (push, pop, top, count, full, empty); sequencing and PC update logic stay in pc_sequencer.

Verification
REQ-036 reset, then start=1, start_addr=0x100 -> pc_out=0x100, count=0, flags=0 next cycle; advance=0 for 3 cycles -> pc_out stays 0x100.
REQ-037 pc=0x010, BRANCH taken offset=0xFC (-4) -> 0x00D; taken=0 -> 0x011; pc=0xFFF NEXT -> 0x000.
REQ-038 pc=0x020 CALL target=0x200, then CALL 0x300 at 0x200, RET, RET -> pc 0x200, 0x300, 0x201, 0x021; count 1,2,1,0.
REQ-039 Five CALLs with RAS_DEPTH=4 -> ras_overflow=1, count=4; four RETs return the first four return addresses in reverse order.
REQ-040 RET with count=0 at pc=0x050 -> pc=0x051, ras_underflow=1; then start -> flag cleared.
REQ-041 reset asserted asynchronously between edges with count=2 -> pc_out=0 and count=0 immediately, before the next edge.
